fetch_buffer: RTL and testbench

Instruction fetch stage with an in-order prefetch queue, sitting directly upstream of the decode stage and replacing the fetch-side PC register and the F/D pipeline register. It issues word-addressed requests to instruction memory over a req/gnt/rvalid handshake and buffers returned instructions with their PCs. It presents one instruction per cycle to decode, honouring StallD. On a taken branch/jump redirect from execute (PCSrcE/PCTargetE), it flushes the queue and discards in-flight responses.

---
 rtl/fetch_buffer.sv | 103 ++++++++++
 tb/tb_fetch_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch stage: PC generation, imem request issue and in-order prefetch queue.
// Feeds decode one instruction per cycle; a redirect flushes and drops stale data.
module fetch_buffer #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] rpc;
  logic [XLEN-1:0] instrQ [DEPTH];
  logic [XLEN-1:0] pcQ [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;

  logic            pop;
  logic            push;
  logic            grant;
  logic [CW:0]     inUse;

  assign ValidD = (count != '0) && !reset;
  assign pop = ValidD && !StallD && !PCSrcE;
  assign inUse = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);
  assign imem_req = !reset && !PCSrcE && (inUse < (CW+1)'(DEPTH));
  assign imem_addr = reset ? RESET_PC : fpc;
  assign grant = imem_req && imem_gnt;
  assign push = imem_rvalid && (discard == '0) && !PCSrcE;

  assign InstrD = ValidD ? instrQ[head] : NOP;
  assign PCD = ValidD ? pcQ[head] : '0;
  assign PCPlus4D = ValidD ? pcQ[head] + XLEN'(1) : '0;

  // Fetch/response pointers, queue occupancy and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc <= RESET_PC;
      rpc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (PCSrcE) begin
        fpc <= PCTargetE;
        rpc <= PCTargetE;
        head <= '0;
        tail <= '0;
        count <= '0;
        discard <= outstanding + CW'(grant) - CW'(imem_rvalid);
      end else begin
        if (grant)
          fpc <= fpc + XLEN'(1);
        if (imem_rvalid && discard != '0)
          discard <= discard - CW'(1);
        if (push) begin
          rpc <= rpc + XLEN'(1);
          tail <= tail + PW'(1);
        end
        if (pop)
          head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage; contents are only visible through the head when ValidD
  always_ff @(posedge clk) begin
    if (push) begin
      instrQ[tail] <= imem_rdata;
      pcQ[tail] <= rpc;
    end
  end

  rvalidWithoutRequest: assert property (
    @(posedge clk) disable iff (reset)
    !(imem_rvalid && outstanding == '0)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: latency-configurable imem model plus a
// stream-level model of which PCs decode must see and when.
module tb_fetch_buffer;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_buffer #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .StallD(StallD),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .ValidD(ValidD),
    .InstrD(InstrD),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } resp_t;

  resp_t       pend[$];
  int unsigned cyc = 0;
  int          lat = 1;
  int          gntPct = 100;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] expPc;
  logic [31:0] expFetch;
  bit          sReq;
  bit          sValid;
  logic [31:0] sAddr;
  logic [31:0] sInstr;
  logic [31:0] sPcd;
  logic [31:0] sPc4;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int stale;
    int live;
    int win;
    bit popNow;
    bit expReq;
    bit expValid;
    bit rvNow;
    bit gNow;
    imem_gnt = !reset && ($urandom_range(99) < gntPct);
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = memWord(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    sReq = imem_req;
    sAddr = imem_addr;
    sValid = ValidD;
    sInstr = InstrD;
    sPcd = PCD;
    sPc4 = PCPlus4D;
    if (reset) begin
      check("rst_req", 32'(sReq), 0);
      check("rst_addr", sAddr, RPC);
      check("rst_valid", 32'(sValid), 0);
      check("rst_instr", sInstr, NOP);
      check("rst_pcd", sPcd, 0);
      check("rst_pc4", sPc4, 0);
    end else begin
      stale = 0;
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].stale) stale++;
      live = pend.size() - stale;
      win = int'(expFetch - expPc);
      expValid = (win - live) > 0;
      popNow = expValid && !StallD && !PCSrcE;
      expReq = !PCSrcE && (win + stale - int'(popNow) < DEPTH);
      check("req", 32'(sReq), 32'(expReq));
      if (sReq) check("addr", sAddr, expFetch);
      check("valid", 32'(sValid), 32'(expValid));
      if (expValid) begin
        check("pcd", sPcd, expPc);
        check("instr", sInstr, memWord(expPc));
        check("pc4", sPc4, expPc + 32'd1);
      end else begin
        check("idle_instr", sInstr, NOP);
        check("idle_pcd", sPcd, 0);
        check("idle_pc4", sPc4, 0);
      end
    end
    rvNow = imem_rvalid;
    gNow = sReq && imem_gnt;
    @(posedge clk);
    #1;
    if (reset) begin
      pend.delete();
      expPc = RPC;
      expFetch = RPC;
    end else begin
      if (rvNow) void'(pend.pop_front());
      if (gNow) begin
        pend.push_back('{addr: expFetch, due: cyc + lat, stale: 1'b0});
        expFetch = expFetch + 32'd1;
      end
      if (PCSrcE) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        expPc = PCTargetE;
        expFetch = PCTargetE;
      end else if (popNow) begin
        expPc = expPc + 32'd1;
      end
    end
    cyc++;
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    StallD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    expPc = RPC;
    expFetch = RPC;
    tick();
    tick();

    reset = 1'b0;
    tick();
    check("c0_req", 32'(sReq), 1);
    check("c0_addr", sAddr, RPC);
    tick();
    check("c1_valid", 32'(sValid), 0);
    tick();
    check("c2_valid", 32'(sValid), 1);
    check("c2_pcd", sPcd, 0);
    check("c2_instr", sInstr, 32'h1000);
    repeat (8) begin
      tick();
      check("stream_valid", 32'(sValid), 1);
    end

    StallD = 1'b1;
    repeat (6) tick();
    check("stall_req_low", 32'(sReq), 0);
    StallD = 1'b0;
    repeat (8) tick();

    lat = 3;
    repeat (8) tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    tick();
    check("r40_addr", sAddr, 32'h40);
    check("r40_gap", 32'(sValid), 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (sValid) found = 1'b1;
    end
    check("r40_seen", 32'(found), 1);
    check("r40_pcd", sPcd, 32'h40);
    check("r40_instr", sInstr, 32'h1040);

    lat = 1;
    repeat (6) tick();
    gntPct = 0;
    repeat (5) tick();
    check("nognt_req", 32'(sReq), 1);
    check("nognt_valid", 32'(sValid), 0);
    check("nognt_instr", sInstr, NOP);
    gntPct = 100;
    repeat (6) tick();

    StallD = 1'b1;
    PCSrcE = 1'b1;
    PCTargetE = 32'h80;
    tick();
    StallD = 1'b0;
    PCSrcE = 1'b0;
    tick();
    check("co_valid1", 32'(sValid), 0);
    check("co_addr", sAddr, 32'h80);
    tick();
    check("co_valid2", 32'(sValid), 0);
    tick();
    check("co_valid3", 32'(sValid), 1);
    check("co_pcd", sPcd, 32'h80);

    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFE;
    tick();
    PCSrcE = 1'b0;
    repeat (8) tick();

    lat = 2;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("mr_valid", 32'(sValid), 0);
    check("mr_addr", sAddr, RPC);
    repeat (3) tick();
    check("mr_pcd", sPcd, RPC);

    for (int seg = 0; seg < 3; seg++) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      lat = $urandom_range(3, 1);
      gntPct = 70;
      for (int c = 0; c < 300; c++) begin
        StallD = ($urandom_range(99) < 25);
        PCSrcE = ($urandom_range(99) < 4);
        PCTargetE = $urandom;
        reset = ($urandom_range(199) == 0);
        tick();
      end
      StallD = 1'b0;
      PCSrcE = 1'b0;
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
